// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte write port and serial status bundle for uart_tx_fifo
`timescale 1ns/1ps
interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx;

    modport master (output wr_en, output wr_data,
                    input  full, input empty, input busy, input tx);
    modport slave  (input  wr_en, input wr_data,
                    output full, output empty, output busy, output tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small write FIFO
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int DEPTH        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_fifo_if.slave   bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];

    logic full, empty, wr_accept, pop, baud_last;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign wr_accept = bus.wr_en && !full;
    assign baud_last = (baud_q == BAUD_LAST);

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.tx    = tx_q;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so queued bytes leave no idle gap
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is decoded from the next state so tx itself is a plain flop
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(wr_accept);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized and directed checks of uart_tx_fifo against a frame-level model
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int C     = 10;
    localparam int FRAME = 10 * C;
    localparam int DEPTH = 8;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst_n;
    uart_tx_fifo_if bus();

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #500 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Frame-level reference: a byte queue plus the time elapsed within the frame on the wire
    logic [7:0] m_q [$];
    logic [7:0] m_done [$];
    logic [7:0] m_cur;
    bit         m_active;
    int         m_t;
    bit         m_full_pre;

    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int slot;
        slot = t / C;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_active = 0;
            m_t      = 0;
        end else begin
            m_full_pre = (m_q.size() == DEPTH);
            if (m_active && m_t == FRAME - 1) begin
                m_done.push_back(m_cur);
                m_active = 0;
            end else if (m_active) begin
                m_t++;
            end
            if (!m_active && m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1;
                m_t      = 0;
            end
            if (bus.wr_en && !m_full_pre) m_q.push_back(bus.wr_data);
        end
    end

    // Per-cycle output comparison and a mid-bit sampling receiver
    bit         chk_en = 0;
    int         busy_cnt = 0;
    logic [7:0] rx_q [$];
    bit         rx_busy = 0;
    int         rx_cnt;
    logic [7:0] rx_sh;
    int         slot;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            rx_busy = 0;
        end else if (chk_en) begin
            check("tx",    bus.tx,    m_active ? frame_bit(m_cur, m_t) : 1'b1);
            check("busy",  bus.busy,  m_active);
            check("full",  bus.full,  m_q.size() == DEPTH);
            check("empty", bus.empty, m_q.size() == 0);
            if (bus.busy) busy_cnt++;
            if (!rx_busy) begin
                if (bus.tx == 1'b0) begin
                    rx_busy = 1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= C/2 && (rx_cnt - C/2) % C == 0) begin
                    slot = (rx_cnt - C/2) / C;
                    if (slot == 0) check("rx_start", bus.tx, 1'b0);
                    else if (slot <= 8) rx_sh[slot-1] = bus.tx;
                    else begin
                        check("rx_stop", bus.tx, 1'b1);
                        rx_q.push_back(rx_sh);
                        rx_busy = 0;
                    end
                end
            end
        end
    end

    task automatic put_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.wr_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && (m_active || m_q.size() != 0); i++) @(negedge clk);
        check("drain_done", (!m_active && m_q.size() == 0), 1'b1);
        idle(3);
    endtask

    task automatic check_rx(input string tag, input byte_q_t want);
        check({tag, "_count"}, rx_q.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), rx_q[i], want[i]);
        rx_q.delete();
        m_done.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},    bus.tx,    1'b1);
        check({tag, "_busy"},  bus.busy,  1'b0);
        check({tag, "_empty"}, bus.empty, 1'b1);
        check({tag, "_full"},  bus.full,  1'b0);
    endtask

    byte_q_t want;

    initial begin
        rst_n       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        #10 rst_n = 1'b0;
        #5 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;

        // Single byte: empty clears after the write edge, tx falls one edge later
        busy_cnt = 0;
        put_byte(8'h55);
        check("single_empty", bus.empty, 1'b0);
        check("single_tx_pre", bus.tx, 1'b1);
        @(negedge clk);
        check("single_tx_fall", bus.tx, 1'b0);
        check("single_busy_rise", bus.busy, 1'b1);
        drain();
        check("single_busy_cycles", busy_cnt, 100);
        want = {};
        want.push_back(8'h55);
        check_rx("single", want);

        // Four back-to-back frames with no idle cycles between them
        busy_cnt = 0;
        put_byte(8'h48); put_byte(8'h49); put_byte(8'h21); put_byte(8'h0A);
        drain();
        check("string_busy_cycles", busy_cnt, 400);
        want = {};
        want.push_back(8'h48); want.push_back(8'h49); want.push_back(8'h21); want.push_back(8'h0A);
        check_rx("string", want);

        // Overflow: ninth write fills the FIFO, tenth is dropped
        for (int i = 0; i < 10; i++) begin
            put_byte(8'(i));
            if (i == 7) check("ovf_not_full_8", bus.full, 1'b0);
            if (i == 8) check("ovf_full_9", bus.full, 1'b1);
        end
        drain();
        want = {};
        for (int i = 0; i < 9; i++) want.push_back(8'(i));
        check_rx("overflow", want);

        // Stop bit of 0x00 followed immediately by an all-ones frame
        put_byte(8'h00); put_byte(8'hFF);
        drain();
        want = {};
        want.push_back(8'h00); want.push_back(8'hFF);
        check_rx("b2b", want);

        // Write lands on the same edge as the STOP->START pop with three bytes queued
        put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
        idle(97);
        put_byte(8'h55);
        check("wdp_not_full", bus.full, 1'b0);
        check("wdp_not_empty", bus.empty, 1'b0);
        drain();
        want = {};
        want.push_back(8'h11); want.push_back(8'h22); want.push_back(8'h33);
        want.push_back(8'h44); want.push_back(8'h55);
        check_rx("wdp", want);

        // Asynchronous reset during data bit 3 of the first frame
        put_byte(8'hC3); put_byte(8'h3C); put_byte(8'h99);
        idle(40);
        #200 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(150);
        check("midrst_quiet_tx", bus.tx, 1'b1);
        check("midrst_no_frames", rx_q.size(), 0);
        put_byte(8'hA5);
        drain();
        want = {};
        want.push_back(8'hA5);
        check_rx("midrst", want);

        // Randomized bursts with gaps, compared against the model's completed frames
        for (int it = 0; it < 20; it++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) != 0) put_byte(8'($urandom));
                else idle(1);
            end
            idle($urandom_range(0, 250));
        end
        drain();
        want = m_done;
        check("rand_some_frames", (want.size() > 0), 1'b1);
        check_rx("rand", want);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
